// File: rtl/instr_sequencer_if.sv
// Fetch-side bus of the instruction sequencer: control inputs, instruction
// memory address/data, and the decoded instruction issued downstream.
interface instr_sequencer_if #(
  parameter int PC_WIDTH = 4
);

  logic                start;
  logic                stall;
  logic [14:0]         im_out_bus;
  logic [PC_WIDTH-1:0] pc;
  logic [6:0]          opcode;
  logic [7:0]          literal;
  logic                instr_valid;
  logic                busy;
  logic                done;
  logic                wrapped;

  // Sequencer side: owns the program counter and the issued instruction.
  modport master (
    input  start,
    input  stall,
    input  im_out_bus,
    output pc,
    output opcode,
    output literal,
    output instr_valid,
    output busy,
    output done,
    output wrapped
  );

  // Environment side: instruction memory plus control unit.
  modport slave (
    output start,
    output stall,
    output im_out_bus,
    input  pc,
    input  opcode,
    input  literal,
    input  instr_valid,
    input  busy,
    input  done,
    input  wrapped
  );

endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from a combinational instruction memory,
// registers the word as opcode/literal and issues it with instr_valid.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | after reset; pc parked at 0, waiting for start
// RUN    | fetching one instruction per unstalled cycle
// HALTED | HALT_OP seen; pc holds halt address, start restarts at 0
module instr_sequencer #(
  parameter int         PC_WIDTH = 4,
  parameter logic [6:0] HALT_OP  = 7'b1111111
) (
  input logic               clk,
  input logic               reset,
  instr_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } stateT;

  stateT               state;
  stateT               stateNext;
  logic [PC_WIDTH-1:0] pcReg;
  logic [PC_WIDTH-1:0] pcNext;
  logic [6:0]          opcodeReg;
  logic [6:0]          opcodeNext;
  logic [7:0]          literalReg;
  logic [7:0]          literalNext;
  logic                validReg;
  logic                validNext;
  logic                wrappedReg;
  logic                wrappedNext;

  logic [6:0]          fetchOp;
  logic [7:0]          fetchLit;
  logic                fetchIsHalt;
  logic                pcAtMax;

  assign fetchOp     = bus.im_out_bus[14:8];
  assign fetchLit    = bus.im_out_bus[7:0];
  assign fetchIsHalt = (fetchOp == HALT_OP);
  assign pcAtMax     = &pcReg;

  // State, PC and instruction register; reset clears everything without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pcReg      <= '0;
      opcodeReg  <= '0;
      literalReg <= '0;
      validReg   <= 1'b0;
      wrappedReg <= 1'b0;
    end else begin
      state      <= stateNext;
      pcReg      <= pcNext;
      opcodeReg  <= opcodeNext;
      literalReg <= literalNext;
      validReg   <= validNext;
      wrappedReg <= wrappedNext;
    end
  end

  // Next-state and fetch decisions. Stall wins over the halt check and wrap;
  // a halt word is never issued, so opcode/literal keep the last real one.
  always_comb begin
    stateNext   = state;
    pcNext      = pcReg;
    opcodeNext  = opcodeReg;
    literalNext = literalReg;
    validNext   = 1'b0;
    wrappedNext = 1'b0;

    case (state)
      IDLE: begin
        pcNext = '0;
        if (bus.start) begin
          stateNext = RUN;
        end
      end

      RUN: begin
        if (!bus.stall) begin
          if (fetchIsHalt) begin
            stateNext = HALTED;
          end else begin
            opcodeNext  = fetchOp;
            literalNext = fetchLit;
            validNext   = 1'b1;
            pcNext      = pcReg + PC_WIDTH'(1);
            wrappedNext = pcAtMax;
          end
        end
      end

      HALTED: begin
        if (bus.start) begin
          pcNext    = '0;
          stateNext = RUN;
        end
      end

      default: begin
        stateNext = IDLE;
        pcNext    = '0;
      end
    endcase
  end

  // Outputs are straight from registers; busy/done decode registered state.
  assign bus.pc          = pcReg;
  assign bus.opcode      = opcodeReg;
  assign bus.literal     = literalReg;
  assign bus.instr_valid = validReg;
  assign bus.wrapped     = wrappedReg;
  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed program steps with
// randomized contents, compared each cycle against a behavioural model.
module tb_instr_sequencer;

  localparam int         PW   = 4;
  localparam int         DEPTH = 16;
  localparam logic [6:0] HALT = 7'b1111111;

  logic clk;
  logic reset;
  logic [14:0] mem [DEPTH];

  instr_sequencer_if #(.PC_WIDTH(PW)) ifc ();

  instr_sequencer #(.PC_WIDTH(PW), .HALT_OP(HALT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  assign ifc.im_out_bus = mem[ifc.pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 running, 2 halted.
  int mMode;
  int mPc;
  int mOp;
  int mLit;
  int mValid;
  int mWrap;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mPc = 0; mOp = 0; mLit = 0; mValid = 0; mWrap = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    int word;
    mValid = 0;
    mWrap  = 0;
    if (mMode == 0) begin
      mPc = 0;
      if (ifc.start) mMode = 1;
    end else if (mMode == 1) begin
      if (!ifc.stall) begin
        word = int'(mem[mPc]);
        if ((word >> 8) == int'(HALT)) begin
          mMode = 2;
        end else begin
          mOp    = word >> 8;
          mLit   = word & 8'hFF;
          mValid = 1;
          mWrap  = (mPc == DEPTH - 1) ? 1 : 0;
          mPc    = (mPc + 1) % DEPTH;
        end
      end
    end else begin
      if (ifc.start) begin
        mPc   = 0;
        mMode = 1;
      end
    end
  endtask

  task automatic compareAll();
    check("pc",          int'(ifc.pc),          mPc);
    check("opcode",      int'(ifc.opcode),      mOp);
    check("literal",     int'(ifc.literal),     mLit);
    check("instr_valid", int'(ifc.instr_valid), mValid);
    check("busy",        int'(ifc.busy),        (mMode == 1) ? 1 : 0);
    check("done",        int'(ifc.done),        (mMode == 2) ? 1 : 0);
    check("wrapped",     int'(ifc.wrapped),     mWrap);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  // Random program; haltAddr < 0 means no halt word anywhere.
  task automatic loadProgram(input int haltAddr);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = {7'($urandom_range(0, 126)), 8'($urandom)};
    end
    if (haltAddr >= 0) mem[haltAddr][14:8] = HALT;
  endtask

  task automatic pulseStart();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic runUntilHalt(input int budget, input bit randStall);
    int n;
    n = 0;
    while (mMode == 1 && n < budget) begin
      ifc.stall = randStall ? ($urandom_range(0, 3) == 0) : 1'b0;
      ifc.start = randStall ? ($urandom_range(0, 5) == 0) : 1'b0;
      tick();
      n++;
    end
    ifc.stall = 1'b0;
    ifc.start = 1'b0;
    check("halt_reached", mMode, 2);
  endtask

  int validCount;
  int haltAt;

  initial begin
    ifc.start = 1'b0;
    ifc.stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    modelReset();

    // Reset state
    reset = 1'b1;
    @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();

    // MOV/ADD/HALT program with exact expected values
    loadProgram(-1);
    mem[0] = {7'b0000010, 8'h05};
    mem[1] = {7'b0000110, 8'h03};
    mem[2] = {HALT, 8'h00};
    validCount = 0;
    pulseStart();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifc.instr_valid) validCount++;
      if (i == 0) begin
        check("p1_op0",  int'(ifc.opcode),  7'b0000010);
        check("p1_lit0", int'(ifc.literal), 8'h05);
      end
      if (i == 1) begin
        check("p1_op1",  int'(ifc.opcode),  7'b0000110);
        check("p1_lit1", int'(ifc.literal), 8'h03);
      end
    end
    check("p1_done",   int'(ifc.done), 1);
    check("p1_pc",     int'(ifc.pc),   2);
    check("p1_nvalid", validCount,     2);

    // Restart from HALTED: pc 0 / busy next cycle, addr0 valid one later
    loadProgram($urandom_range(4, 12));
    pulseStart();
    check("rs_pc",   int'(ifc.pc),          0);
    check("rs_busy", int'(ifc.busy),        1);
    check("rs_done", int'(ifc.done),        0);
    tick();
    check("rs_valid", int'(ifc.instr_valid), 1);
    check("rs_op0",   int'(ifc.opcode),      int'(mem[0][14:8]));
    runUntilHalt(200, 1'b1);

    // Stall held three cycles while pc=1
    loadProgram(10);
    pulseStart();
    tick();
    check("st_pc1", int'(ifc.pc), 1);
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_hold_pc", int'(ifc.pc), 1);
    end
    ifc.stall = 1'b0;
    tick();
    check("st_resume_op", int'(ifc.opcode), int'(mem[1][14:8]));
    runUntilHalt(100, 1'b0);

    // Stall coinciding with HALT_OP: halt only once stall drops
    haltAt = $urandom_range(2, 8);
    loadProgram(haltAt);
    pulseStart();
    while (mPc != haltAt && mMode == 1) tick();
    ifc.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("sh_done", int'(ifc.done), 0);
      check("sh_busy", int'(ifc.busy), 1);
    end
    ifc.stall = 1'b0;
    tick();
    check("sh_halt_done", int'(ifc.done), 1);
    check("sh_halt_pc",   int'(ifc.pc),   haltAt);

    // Full 16-word program with no halt: wrap and continue, random stalls/starts
    loadProgram(-1);
    pulseStart();
    for (int i = 0; i < 45; i++) begin
      ifc.stall = ($urandom_range(0, 4) == 0);
      ifc.start = ($urandom_range(0, 6) == 0);
      tick();
    end
    ifc.start = 1'b0;
    ifc.stall = 1'b0;

    // Asynchronous reset mid-run at pc=3 while stalled
    while (mPc != 3) tick();
    ifc.stall = 1'b1;
    tick();
    #1;
    reset = 1'b1;
    #1;
    modelReset();
    check("ar_pc",     int'(ifc.pc),          0);
    check("ar_op",     int'(ifc.opcode),      0);
    check("ar_lit",    int'(ifc.literal),     0);
    check("ar_valid",  int'(ifc.instr_valid), 0);
    check("ar_busy",   int'(ifc.busy),        0);
    check("ar_wrap",   int'(ifc.wrapped),     0);
    @(negedge clk);
    reset = 1'b0;
    ifc.stall = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("ar_idle_busy", int'(ifc.busy), 0);

    // Runs again after reset
    loadProgram($urandom_range(5, 15));
    pulseStart();
    runUntilHalt(200, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Front end of the datapath: owns the program counter and presents an address to instruction memory.
- Registers the returned 15-bit instruction word and issues it to the control unit as a 7-bit `opcode` plus an 8-bit `literal`, qualified by `instr_valid`.
- Provides start/stall/halt sequencing; together with the control unit it forms the fetch-decode path of the CPU.

## Interface

Parameters:
- PC_WIDTH, 4, program counter width; instruction memory depth 2^PC_WIDTH.
- HALT_OP, 7'b1111111, opcode value that halts sequencing; never issued downstream.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; begins or restarts execution at address 0.
- stall  input  1  holds the PC and instruction register for the cycle.
- im_out_bus  input  15  instruction word at address `pc`; combinational memory read; [14:8] opcode, [7:0] literal.
- pc  output  PC_WIDTH  instruction memory address.
- opcode  output  7  registered opcode to the control unit.
- literal  output  8  registered literal to the datapath literal mux input.
- instr_valid  output  1  `opcode`/`literal` are a new instruction to execute this cycle.
- busy  output  1  high in RUN.
- done  output  1  high in HALTED.
- wrapped  output  1  one-cycle pulse when `pc` wraps from its maximum value to 0.

## Operation

- States: IDLE, RUN, HALTED (2-bit encoding).
- Reset values: state IDLE, pc 0, opcode 0, literal 0, instr_valid 0, busy 0, done 0, wrapped 0.
- Opcode 7'b0000000 is a real register-load instruction. Consumers must gate register loads with `instr_valid`; a held or reset `opcode` is never to be executed.
- IDLE:
  - pc held at 0, instr_valid 0.
  - start=1 -> RUN next edge.
- RUN, stall=1:
  - pc, opcode and literal held; instr_valid <= 0.
  - No state change. Stall has priority over the HALT_OP check and over wrap.
- RUN, stall=0, im_out_bus[14:8] != HALT_OP:
  - opcode <= im_out_bus[14:8]; literal <= im_out_bus[7:0]; instr_valid <= 1.
  - pc <= pc + 1, modulo 2^PC_WIDTH.
  - If pc was all-ones, wrapped <= 1 and execution continues from 0.
- RUN, stall=0, im_out_bus[14:8] == HALT_OP:
  - opcode and literal keep their previous values; instr_valid <= 0.
  - pc stays at the halt address; state -> HALTED.
- HALTED:
  - done 1, instr_valid 0, pc holds the halt address.
  - start=1 -> pc <= 0, state -> RUN, done <= 0.
- `start` while in RUN is ignored.
- `wrapped` is 0 in every cycle not described above.
- busy = (state==RUN); done = (state==HALTED). Both are decoded from registered state.
- An asserted reset in any state, including mid-stall, returns all outputs to their reset values immediately, with no clock edge required.

## Timing

- Fetch latency is one cycle:
  - An instruction at address n is presented on `pc` in cycle k.
  - It appears on opcode/literal with instr_valid=1 in cycle k+1, while pc = n+1.
- Throughput: one instruction per cycle with stall=0.
- Each stall cycle inserts exactly one instr_valid=0 bubble.
- start -> first instr_valid: start sampled at edge t; RUN from t; first instruction valid after edge t+1.
- HALT_OP at address h, sampled at edge t: done=1 and busy=0 after edge t. The last valid instruction is the one from address h-1.

## Test plan

- Program MOV A,Lit 0x05 (addr0); ADD A,Lit 0x03 (addr1); HALT_OP (addr2); pulse start. -> Cycle 2: opcode 7'b0000010, literal 0x05. Cycle 3: opcode 7'b0000110, literal 0x03. Then done=1, pc=2, with exactly 2 instr_valid cycles.
- Stall held for 3 cycles while pc=1. -> pc stays 1, opcode unchanged, instr_valid 0 for 3 cycles, then resumes with addr1's instruction.
- 16-word program with no HALT_OP, PC_WIDTH=4. -> wrapped pulses for one cycle as pc goes 15->0; opcode from addr15 is issued with instr_valid=1; execution continues.
- Stall and HALT_OP in the same cycle. -> stays in RUN, done=0. The halt is taken the first cycle stall drops.
- In HALTED, assert start. -> next cycle pc=0, done=0, busy=1; addr0's instruction is valid one cycle later.
- Assert reset mid-run with pc=3 and stall=1. -> pc=0, opcode=0, literal=0, instr_valid=0, busy=0 asynchronously. After reset is released, state is IDLE until start.
